// File: rtl/soc_system_hex_writer.sv
// Avalon-MM master turning a hex-digit stream into 7-segment PIO writes, skipping repeats; 1-cycle write, in_ready low while busy.
// Define HEX_WRITER_READBACK_EN to add a readback compare with a single retry and a sticky err flag.
module soc_system_hex_writer #(
  parameter logic [1:0] ADDR   = 2'd0,
  parameter bit         INVERT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_data,
  input  logic        in_blank,
  output logic        in_ready,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic        read_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Active-high segment map, bit0 = seg a ... bit6 = seg g.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  state_e     state_q, state_d;
  logic [6:0] mirror_q, mirror_d;
  logic [6:0] pend_q, pend_d;
  logic [6:0] in_pattern;

`ifdef HEX_WRITER_READBACK_EN
  logic retry_q, retry_d;
  logic err_q, err_d;
  logic unused_readdata;
  assign unused_readdata = ^readdata[31:7];
  assign err = err_q;
`else
  logic unused_readback_inputs;
  assign unused_readback_inputs = ^{readdata, err_clr};
  assign err = 1'b0;
`endif

  always_comb begin
    in_pattern = in_blank ? 7'h00 : seg_decode(in_data);
    if (INVERT) begin
      in_pattern = ~in_pattern;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    mirror_d   = mirror_q;
    pend_d     = pend_q;
    in_ready   = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = ADDR;
    writedata  = 32'h0;
`ifdef HEX_WRITER_READBACK_EN
    retry_d    = retry_q;
    err_d      = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
`endif

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // Pattern already on the display: consume the digit without a bus cycle.
        if (in_valid && (in_pattern != mirror_q)) begin
          pend_d  = in_pattern;
          state_d = WRITE;
        end
      end

      WRITE: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = {25'b0, pend_q};
        if (!waitrequest) begin
          mirror_d = pend_q;
`ifdef HEX_WRITER_READBACK_EN
          state_d  = READ;
`else
          state_d  = IDLE;
`endif
        end
      end

`ifdef HEX_WRITER_READBACK_EN
      READ: begin
        chipselect = 1'b1;
        read_n     = 1'b0;
        if (!waitrequest) begin
          if (readdata[6:0] == pend_q) begin
            retry_d = 1'b0;
            state_d = IDLE;
          end else if (!retry_q) begin
            err_d   = 1'b1;
            retry_d = 1'b1;
            state_d = WRITE;
          end else begin
            err_d   = 1'b1;
            retry_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mirror_q <= 7'h7F;
      pend_q   <= 7'h00;
`ifdef HEX_WRITER_READBACK_EN
      retry_q  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mirror_q <= mirror_d;
      pend_q   <= pend_d;
`ifdef HEX_WRITER_READBACK_EN
      retry_q  <= retry_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule
